// File: rtl/decoder_timer_sequencer.sv
// Command sequencer and sole bus master for the decoder's 16-bit Avalon-MM interval timer.
// Expands START/STOP/SNAPSHOT commands into register accesses and services timeout interrupts.
module decoder_timer_sequencer #(
    parameter logic [31:0] DEFAULT_PERIOD = 32'd49999,
    parameter bit          AUTOSTART      = 1'b1,
    parameter int unsigned TICK_W         = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [31:0]       cmd_period_i,
    input  logic              cmd_continuous_i,
    input  logic              cmd_irq_en_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_data_o,
    output logic              tick_o,
    output logic [TICK_W-1:0] tick_count_o,
    output logic [2:0]        tmr_address_o,
    output logic              tmr_chipselect_o,
    output logic              tmr_write_n_o,
    output logic [15:0]       tmr_writedata_o,
    input  logic [15:0]       tmr_readdata_i,
    input  logic              tmr_irq_i
);

    localparam logic [1:0] OpStart = 2'd0;
    localparam logic [1:0] OpStop  = 2'd1;
    localparam logic [1:0] OpSnap  = 2'd2;

    localparam logic [2:0] RegStatus  = 3'd0;
    localparam logic [2:0] RegControl = 3'd1;
    localparam logic [2:0] RegPeriodL = 3'd2;
    localparam logic [2:0] RegPeriodH = 3'd3;
    localparam logic [2:0] RegSnapL   = 3'd4;
    localparam logic [2:0] RegSnapH   = 3'd5;

    typedef enum logic [3:0] {
        StIdle,
        StPl,
        StPh,
        StGap,
        StCtl,
        StStp,
        StSnw,
        StRdl,
        StRdh,
        StRdc,
        StClr
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       period_q, period_d;
    logic              cont_q, cont_d;
    logic              ie_q, ie_d;
    logic              pending_q, pending_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic [TICK_W-1:0] tick_count_q, tick_count_d;

    // Interrupt service and a pending autostart both outrank new commands.
    assign cmd_ready_o  = (state_q == StIdle) && !tmr_irq_i && !pending_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign tick_o       = (state_q == StClr);
    assign tick_count_o = tick_count_q;

    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        cont_d       = cont_q;
        ie_d         = ie_q;
        pending_d    = pending_q;
        rsp_valid_d  = 1'b0;
        rsp_data_d   = rsp_data_q;
        tick_count_d = tick_count_q;

        unique case (state_q)
            StIdle: begin
                if (tmr_irq_i) begin
                    state_d = StClr;
                end else if (pending_q) begin
                    state_d   = StPl;
                    period_d  = DEFAULT_PERIOD;
                    cont_d    = 1'b1;
                    ie_d      = 1'b1;
                    pending_d = 1'b0;
                end else if (cmd_valid_i) begin
                    unique case (cmd_op_i)
                        OpStart: begin
                            state_d  = StPl;
                            period_d = cmd_period_i;
                            cont_d   = cmd_continuous_i;
                            ie_d     = cmd_irq_en_i;
                        end
                        OpStop:  state_d = StStp;
                        OpSnap:  state_d = StSnw;
                        default: state_d = StIdle;
                    endcase
                end
            end
            StPl:  state_d = StPh;
            StPh:  state_d = StGap;
            StGap: state_d = StCtl;
            StCtl: state_d = StIdle;
            StStp: state_d = StIdle;
            StSnw: state_d = StRdl;
            StRdl: state_d = StRdh;
            StRdh: begin
                rsp_data_d[15:0] = tmr_readdata_i;
                state_d          = StRdc;
            end
            StRdc: begin
                rsp_data_d[31:16] = tmr_readdata_i;
                rsp_valid_d       = 1'b1;
                state_d           = StIdle;
            end
            StClr: begin
                tick_count_d = tick_count_q + TICK_W'(1);
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus outputs depend on registered state and shadows only.
    always_comb begin
        tmr_address_o    = RegStatus;
        tmr_chipselect_o = 1'b0;
        tmr_write_n_o    = 1'b1;
        tmr_writedata_o  = 16'h0000;

        unique case (state_q)
            StPl: begin
                tmr_address_o    = RegPeriodL;
                tmr_chipselect_o = 1'b1;
                tmr_write_n_o    = 1'b0;
                tmr_writedata_o  = period_q[15:0];
            end
            StPh: begin
                tmr_address_o    = RegPeriodH;
                tmr_chipselect_o = 1'b1;
                tmr_write_n_o    = 1'b0;
                tmr_writedata_o  = period_q[31:16];
            end
            StCtl: begin
                tmr_address_o    = RegControl;
                tmr_chipselect_o = 1'b1;
                tmr_write_n_o    = 1'b0;
                tmr_writedata_o  = {12'h000, 1'b0, 1'b1, cont_q, ie_q};
            end
            StStp: begin
                tmr_address_o    = RegControl;
                tmr_chipselect_o = 1'b1;
                tmr_write_n_o    = 1'b0;
                tmr_writedata_o  = {12'h000, 1'b1, 1'b0, cont_q, ie_q};
            end
            StSnw: begin
                tmr_address_o    = RegSnapL;
                tmr_chipselect_o = 1'b1;
                tmr_write_n_o    = 1'b0;
            end
            StRdl: tmr_address_o = RegSnapL;
            StRdh: tmr_address_o = RegSnapH;
            StRdc: tmr_address_o = RegSnapH;
            StClr: begin
                tmr_address_o    = RegStatus;
                tmr_chipselect_o = 1'b1;
                tmr_write_n_o    = 1'b0;
            end
            default: tmr_address_o = RegStatus;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            period_q     <= 32'h0000_0000;
            cont_q       <= 1'b0;
            ie_q         <= 1'b0;
            pending_q    <= AUTOSTART;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 32'h0000_0000;
            tick_count_q <= '0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            cont_q       <= cont_d;
            ie_q         <= ie_d;
            pending_q    <= pending_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            tick_count_q <= tick_count_d;
        end
    end

endmodule

// File: tb/tb_decoder_timer_sequencer.sv
// Directed bench for decoder_timer_sequencer with a small behavioural timer slave;
// expected bus writes and snapshot responses are queued at stimulus time and checked per cycle.
module tb_decoder_timer_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_period;
    logic        cmd_continuous;
    logic        cmd_irq_en;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        tick;
    logic [3:0]  tick_count;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata = 16'h0000;
    logic        tmr_irq;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    decoder_timer_sequencer #(
        .DEFAULT_PERIOD(32'd49999),
        .AUTOSTART     (1'b1),
        .TICK_W        (4)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .cmd_valid_i     (cmd_valid),
        .cmd_ready_o     (cmd_ready),
        .cmd_op_i        (cmd_op),
        .cmd_period_i    (cmd_period),
        .cmd_continuous_i(cmd_continuous),
        .cmd_irq_en_i    (cmd_irq_en),
        .rsp_valid_o     (rsp_valid),
        .rsp_data_o      (rsp_data),
        .tick_o          (tick),
        .tick_count_o    (tick_count),
        .tmr_address_o   (tmr_address),
        .tmr_chipselect_o(tmr_chipselect),
        .tmr_write_n_o   (tmr_write_n),
        .tmr_writedata_o (tmr_writedata),
        .tmr_readdata_i  (tmr_readdata),
        .tmr_irq_i       (tmr_irq)
    );

    // Behavioural interval timer: counts period+1 clocks, timeout flag cleared by a status write.
    logic [31:0] m_per  = 32'h0;
    logic [31:0] m_cnt  = 32'h0;
    logic [31:0] m_snap = 32'h0;
    logic        m_run  = 1'b0;
    logic        m_cont = 1'b0;
    logic        m_ito  = 1'b0;
    logic        m_to   = 1'b0;
    logic [31:0] snap_ovr;

    assign tmr_irq = m_to & m_ito;

    always @(posedge clk) begin
        tmr_readdata <= (tmr_address == 3'd4) ? m_snap[15:0] :
                        (tmr_address == 3'd5) ? m_snap[31:16] : 16'h0000;
        if (m_run) begin
            if (m_cnt == 32'h0) begin
                m_to  <= 1'b1;
                m_cnt <= m_per;
                if (!m_cont) m_run <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 32'h1;
            end
        end
        if (tmr_chipselect === 1'b1 && tmr_write_n === 1'b0) begin
            case (tmr_address)
                3'd0: m_to <= 1'b0;
                3'd1: begin
                    m_ito  <= tmr_writedata[0];
                    m_cont <= tmr_writedata[1];
                    if (tmr_writedata[2]) begin
                        m_run <= 1'b1;
                        m_cnt <= m_per;
                    end
                    if (tmr_writedata[3]) m_run <= 1'b0;
                end
                3'd2: m_per[15:0]  <= tmr_writedata;
                3'd3: m_per[31:16] <= tmr_writedata;
                3'd4, 3'd5: m_snap <= snap_ovr;
                default: ;
            endcase
        end
    end

    typedef struct {
        int          cyc;
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rsp_t;

    wr_t        wq[$];
    rsp_t       rq[$];
    logic [3:0] exp_tc = 4'h0;
    logic       sh_c   = 1'b0;
    logic       sh_ie  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic push_wr(input int c, input logic [2:0] a, input logic [15:0] d);
        wr_t e;
        e.cyc  = c;
        e.addr = a;
        e.data = d;
        wq.push_back(e);
    endtask

    task automatic push_rsp(input int c, input logic [31:0] d);
        rsp_t r;
        r.cyc  = c;
        r.data = d;
        rq.push_back(r);
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Runs every falling edge: bus writes, tick, tick_count and snapshot responses.
    task automatic mon_step();
        wr_t  e;
        rsp_t r;
        logic exp_tick;
        if (cyc < 1) return;
        check("tick_count", 64'(tick_count), 64'(exp_tc));
        while (wq.size() > 0 && wq[0].cyc < cyc) begin
            check("wr_missing", 64'(cyc), 64'(wq[0].cyc));
            void'(wq.pop_front());
        end
        exp_tick = 1'b0;
        if (tmr_chipselect === 1'b1 && tmr_write_n === 1'b0) begin
            if (wq.size() == 0) begin
                check("wr_unexpected", 64'(wq.size()), 64'd1);
            end else begin
                e = wq.pop_front();
                check("wr_cyc", 64'(cyc), 64'(e.cyc));
                check("wr_addr", 64'(tmr_address), 64'(e.addr));
                check("wr_data", 64'(tmr_writedata), 64'(e.data));
                if (e.addr == 3'd0 && e.cyc == cyc) begin
                    exp_tick = 1'b1;
                    exp_tc   = exp_tc + 4'h1;
                end
            end
        end else begin
            check("bus_idle", 64'({tmr_chipselect, tmr_write_n, tmr_writedata}),
                  64'({1'b0, 1'b1, 16'h0000}));
        end
        check("tick", 64'(tick), 64'(exp_tick));
        while (rq.size() > 0 && rq[0].cyc < cyc) begin
            check("rsp_missing", 64'(cyc), 64'(rq[0].cyc));
            void'(rq.pop_front());
        end
        if (rsp_valid !== 1'b0) begin
            if (rq.size() == 0) begin
                check("rsp_unexpected", 64'(rq.size()), 64'd1);
            end else begin
                r = rq.pop_front();
                check("rsp_cyc", 64'(cyc), 64'(r.cyc));
                check("rsp_data", 64'(rsp_data), 64'(r.data));
            end
        end
    endtask

    // Presents a command until accepted (bounded) and queues the bus traffic it must cause.
    task automatic issue(input logic [1:0] op, input logic [31:0] per, input logic c,
                         input logic ie, output int acc);
        cmd_op         = op;
        cmd_period     = per;
        cmd_continuous = c;
        cmd_irq_en     = ie;
        cmd_valid      = 1'b1;
        acc            = -1;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready === 1'b1) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        check("cmd_accepted", 64'(acc >= 0), 64'd1);
        if (acc < 0) begin
            cmd_valid = 1'b0;
            return;
        end
        case (op)
            2'd0: begin
                push_wr(acc + 1, 3'd2, per[15:0]);
                push_wr(acc + 2, 3'd3, per[31:16]);
                push_wr(acc + 4, 3'd1, {12'h000, 2'b01, c, ie});
                sh_c  = c;
                sh_ie = ie;
            end
            2'd1: push_wr(acc + 1, 3'd1, {12'h000, 2'b10, sh_c, sh_ie});
            2'd2: begin
                push_wr(acc + 1, 3'd4, 16'h0000);
                push_rsp(acc + 5, snap_ovr);
            end
            default: ;
        endcase
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic ready_window(input string tag, input int acc, input int n);
        for (int k = 1; k < n; k++) begin
            goto_cyc(acc + k);
            check(tag, 64'(cmd_ready), 64'd0);
        end
        goto_cyc(acc + n);
        check(tag, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        int acc;
        int t;
        reset          = 1'b1;
        cmd_valid      = 1'b0;
        cmd_op         = 2'd0;
        cmd_period     = 32'h0;
        cmd_continuous = 1'b0;
        cmd_irq_en     = 1'b0;
        snap_ovr       = 32'h0;
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        // Reset state.
        @(negedge clk);
        goto_cyc(2);
        check("rst_ready", 64'(cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_addr", 64'(tmr_address), 64'd0);
        check("rst_wn", 64'(tmr_write_n), 64'd1);

        // Autostart with the default period after reset release.
        reset = 1'b0;
        push_wr(3, 3'd2, 16'hC34F);
        push_wr(4, 3'd3, 16'h0000);
        push_wr(6, 3'd1, 16'h0007);
        sh_c  = 1'b1;
        sh_ie = 1'b1;
        check("auto_ready_low", 64'(cmd_ready), 64'd0);
        ready_window("auto_ready", 2, 5);

        // START with a 32-bit period.
        issue(2'd0, 32'h0001_0003, 1'b1, 1'b1, acc);
        ready_window("start_ready", acc, 5);

        // SNAPSHOT.
        snap_ovr = 32'h0002_1A2B;
        issue(2'd2, 32'h0, 1'b0, 1'b0, acc);
        ready_window("snap_ready", acc, 5);

        // Reserved op: accepted with no bus activity.
        issue(2'd3, 32'hFFFF_FFFF, 1'b1, 1'b1, acc);
        goto_cyc(acc + 2);
        check("rsvd_ready", 64'(cmd_ready), 64'd1);

        // Period 9: a timeout every 10 clocks, each serviced one cycle after irq rises.
        issue(2'd0, 32'd9, 1'b1, 1'b1, t);
        for (int k = 0; k < 4; k++) push_wr(t + 16 + 10 * k, 3'd0, 16'h0000);
        goto_cyc(t + 37);
        check("tick_count_3", 64'(tick_count), 64'd3);
        goto_cyc(t + 45);
        check("irq_blocks_ready", 64'(cmd_ready), 64'd0);
        issue(2'd1, 32'h0, 1'b0, 1'b0, acc);
        check("stop_after_clr", 64'(acc), 64'(t + 47));
        ready_window("stop_ready", acc, 2);

        // Twelve more ticks wrap the 4-bit count 15 -> 0.
        issue(2'd0, 32'd9, 1'b1, 1'b1, t);
        for (int k = 0; k < 12; k++) push_wr(t + 16 + 10 * k, 3'd0, 16'h0000);
        goto_cyc(t + 126);
        check("tick_count_15", 64'(tick_count), 64'd15);
        goto_cyc(t + 127);
        check("tick_count_wrap", 64'(tick_count), 64'd0);
        issue(2'd1, 32'h0, 1'b0, 1'b0, acc);
        check("stop_plain_cyc", 64'(acc), 64'(t + 127));
        ready_window("stop_plain_ready", acc, 2);
        check("rsp_hold", 64'(rsp_data), 64'h0002_1A2B);

        // Reset during GAP aborts the sequence; autostart then reruns.
        issue(2'd0, 32'h1234_5678, 1'b0, 1'b0, t);
        goto_cyc(t + 3);
        reset = 1'b1;
        void'(wq.pop_back());
        goto_cyc(t + 4);
        check("gap_rst_cs", 64'(tmr_chipselect), 64'd0);
        check("gap_rst_wn", 64'(tmr_write_n), 64'd1);
        check("gap_rst_addr", 64'(tmr_address), 64'd0);
        check("gap_rst_ready", 64'(cmd_ready), 64'd0);
        check("gap_rst_rsp_data", 64'(rsp_data), 64'd0);
        reset = 1'b0;
        push_wr(t + 5, 3'd2, 16'hC34F);
        push_wr(t + 6, 3'd3, 16'h0000);
        push_wr(t + 8, 3'd1, 16'h0007);
        sh_c  = 1'b1;
        sh_ie = 1'b1;
        ready_window("reauto_ready", t + 4, 5);

        goto_cyc(t + 14);
        check("wr_queue_drained", 64'(wq.size()), 64'd0);
        check("rsp_queue_drained", 64'(rq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
